// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states and byte-masked stores
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [31:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  // Operation that takes effect at this edge (entry into RESP).
  logic              commit;
  logic              commit_we;
  logic [ADDR_W-1:0] commit_addr;
  logic [3:0]        commit_be;
  logic [31:0]       commit_wdata;

  // Next-state, counter, latch and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    commit       = 1'b0;
    commit_we    = we_q;
    commit_addr  = addr_q;
    commit_be    = be_q;
    commit_wdata = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          be_d    = be;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            // No wait states: the request completes on its acceptance edge,
            // so the live inputs are the ones being latched.
            state_d      = S_RESP;
            commit       = 1'b1;
            commit_we    = we;
            commit_addr  = addr;
            commit_be    = be;
            commit_wdata = wdata;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (commit && !commit_we) begin
      rdata_d = mem[commit_addr];
    end
    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Byte-lane masked store; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && commit_we) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_be[i]) begin
          mem[commit_addr][8*i +: 8] <= commit_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        we;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        req;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;

  logic        req_z;
  logic [31:0] rdata_z;
  logic        ready_z;
  logic        busy_z;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;

  dmem_responder #(.WAIT_CYCLES(2), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy)
  );

  dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(10)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata_z), .ready(ready_z), .busy(busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] ref_read(input logic [9:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 32'd0;
  endfunction

  // Full transaction on the WAIT_CYCLES=2 instance; entered 1 time unit after an edge, DUT idle.
  task automatic run_op(input logic w, input logic [9:0] a, input logic [3:0] b,
                        input logic [31:0] d);
    we = w; addr = a; be = b; wdata = d; req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk("busy_in_op", 32'(busy), 32'd1);
      chk("ready_timing", 32'(ready), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) req = 1'b0;
    end
    if (w) ref_mem[int'(a)] = merge(ref_read(a), d, b);
    else   ref_rdata = ref_read(a);
    @(posedge clk); #1;
    chk("busy_after", 32'(busy), 32'd0);
    chk("ready_after", 32'(ready), 32'd0);
    chk("rdata", rdata, ref_rdata);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_z = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    ref_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready_z", 32'(ready_z), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then load at 0x005.
    run_op(1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    run_op(1'b0, 10'h005, 4'h0, 32'h0);
    chk("raw_deadbeef", rdata, 32'hDEADBEEF);

    // Partial write.
    run_op(1'b1, 10'h010, 4'hF, 32'h11223344);
    run_op(1'b1, 10'h010, 4'b0101, 32'hAABBCCDD);
    run_op(1'b0, 10'h010, 4'hF, 32'h0);
    chk("partial_write", rdata, 32'h11BB33DD);

    // Abort: store accepted, req dropped during WAIT.
    run_op(1'b1, 10'h020, 4'hF, 32'h0BADF00D);
    run_op(1'b0, 10'h005, 4'h0, 32'h0);
    we = 1'b1; addr = 10'h020; be = 4'hF; wdata = 32'h55555555; req = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd1);
    req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", 32'(ready), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    chk("abort_rdata_kept", rdata, ref_rdata);
    run_op(1'b0, 10'h020, 4'h0, 32'h0);
    chk("abort_mem_kept", rdata, 32'h0BADF00D);

    // Reset in the WAIT cycle of a store.
    run_op(1'b1, 10'h030, 4'hF, 32'hCAFEF00D);
    run_op(1'b0, 10'h005, 4'h0, 32'h0);
    we = 1'b1; addr = 10'h030; be = 4'hF; wdata = 32'h12121212; req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    rst = 1'b0; req = 1'b0; ref_rdata = 32'd0;
    @(posedge clk); #1;
    run_op(1'b0, 10'h030, 4'h0, 32'h0);
    chk("midrst_mem_kept", rdata, 32'hCAFEF00D);

    // be=0000 store completes but changes nothing.
    run_op(1'b1, 10'h040, 4'hF, 32'h40404040);
    run_op(1'b0, 10'h005, 4'h0, 32'h0);
    run_op(1'b1, 10'h040, 4'h0, 32'hFFFFFFFF);
    chk("be0_rdata_kept", rdata, 32'hDEADBEEF);
    run_op(1'b0, 10'h040, 4'h0, 32'h0);
    chk("be0_mem_kept", rdata, 32'h40404040);

    // Randomized traffic over a preloaded window.
    for (int i = 0; i < 16; i++) run_op(1'b1, 10'(10'h100 + i), 4'hF, $urandom);
    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), 10'(10'h100 + $urandom_range(0, 15)),
             4'($urandom), $urandom);
    end

    // Zero-wait instance: store, then req held high turns into a load.
    we = 1'b1; addr = 10'h077; be = 4'hF; wdata = 32'h13579BDF; req_z = 1'b1;
    @(posedge clk); #1;
    chk("z_ready_c1", 32'(ready_z), 32'd1);
    chk("z_busy_c1", 32'(busy_z), 32'd1);
    we = 1'b0;
    @(posedge clk); #1;
    chk("z_ready_c2", 32'(ready_z), 32'd0);
    chk("z_busy_c2", 32'(busy_z), 32'd0);
    @(posedge clk); #1;
    chk("z_ready_c3", 32'(ready_z), 32'd1);
    chk("z_rdata_c3", rdata_z, 32'h13579BDF);
    req_z = 1'b0;
    @(posedge clk); #1;
    chk("z_ready_c4", 32'(ready_z), 32'd0);
    chk("z_busy_c4", 32'(busy_z), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
